// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: multi-cycle unsigned shift-add multiplier with the HI/LO
// register pair. A multiply takes WIDTH RUN cycles plus one DONE cycle; HI/LO
// change only when a product completes. mfhi/mflo reads are served
// combinationally from the registered HI/LO, and stall tells the requester to
// hold its inputs while the unit cannot serve the request.
module mul_hilo_unit #(
  parameter int         WIDTH  = 32,
  parameter logic [2:0] OP_MUL = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       alu_op,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [1:0] SEL_HI = 2'b01;
  localparam logic [1:0] SEL_LO = 2'b10;

  logic [1:0]         state_q,  state_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic [CW-1:0]      cnt_q,    cnt_d;

  logic               mul_req_s;
  logic               rd_req_s;
  logic [2*WIDTH-1:0] acc_sum_s;

  assign mul_req_s = op_valid & (alu_op == OP_MUL);
  assign rd_req_s  = op_valid & ((sel == SEL_HI) | (sel == SEL_LO));

  // Conditional add of the shifted multiplicand for the current multiplier bit
  // (wraps modulo 2^(2*WIDTH)).
  assign acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // Next-state logic: FSM sequencing and the shift-add datapath.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mul_req_s) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = {(2*WIDTH){1'b0}};
          cnt_d    = {CW{1'b0}};
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last step: commit the product including this cycle's add.
          hi_d    = acc_sum_s[2*WIDTH-1:WIDTH];
          lo_d    = acc_sum_s[WIDTH-1:0];
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any product in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  // Reads wait out a product in flight; a new mul waits for the next IDLE.
  assign stall = ((state_q == S_RUN) & (mul_req_s | rd_req_s)) |
                 ((state_q == S_DONE) & mul_req_s);

  // mfhi/mflo read mux from the registered HI/LO.
  always_comb begin
    rd_data = {WIDTH{1'b0}};
    case (sel)
      SEL_HI:  rd_data = hi_q;
      SEL_LO:  rd_data = lo_q;
      default: rd_data = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: doc/mul_hilo_unit.md
# mul_hilo_unit

Multi-cycle unsigned multiplier with the architectural HI/LO register pair for the MIPS datapath. It consumes the decoded ALU command (`alu_op`) and the HI/LO read select (`sel`) produced by ALU control. It executes `mul` as a shift-add over WIDTH cycles and serves `mfhi`/`mflo` reads. It sits beside the main ALU in EX and drives a stall to the pipeline/FSM control while a product is in flight.

## Interface

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.
- OP_MUL, 3'b100: `alu_op` encoding that requests a multiply.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- op_valid  in  1  `alu_op`/`sel`/operands are valid this cycle.
- alu_op  in  3  decoded ALU operation; only OP_MUL is acted on.
- sel  in  2  HI/LO read select: 00 none, 01 HI (`mfhi`), 10 LO (`mflo`), 11 reserved.
- a  in  WIDTH  multiplicand (rs).
- b  in  WIDTH  multiplier (rt).
- busy  out  1  multiply in progress (state RUN).
- done  out  1  one-cycle pulse; HI/LO hold the new product.
- stall  out  1  request cannot be served this cycle; the requester holds all inputs.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  `mfhi`/`mflo` result.

## Operation

- mul_req = op_valid & (alu_op == OP_MUL); rd_req = op_valid & (sel == 01 or sel == 10).
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE: on mul_req, latch mcand = zero-extended a (2*WIDTH bits), mplier = b, clear acc and cnt, then go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle, if mplier[0] then acc += mcand (mod 2^(2*WIDTH)). Then mcand <<= 1, mplier >>= 1, cnt += 1.
    - When cnt == WIDTH-1, the same edge writes {hi,lo} = the final acc value (including that cycle's add) and the FSM goes to DONE.
  - DONE: done = 1 for this cycle only, then go to IDLE unconditionally.
- Arithmetic is unsigned only. There is no early termination, so latency is fixed regardless of operand values.
- The cnt width is ceil(log2(WIDTH)).
- HI/LO are written only on completion. A mul request does not disturb HI/LO until its product is ready.
- rd_data is combinational from the registered hi/lo:
  - sel 01 gives hi.
  - sel 10 gives lo.
  - 00 or 11 gives 0.
- Stall rules:
  - stall = (RUN & (mul_req | rd_req)) | (DONE & mul_req).
  - `mfhi`/`mflo` in IDLE or DONE never stall; in DONE they return the new product.
  - A mul_req during RUN or DONE is not queued. It is accepted in the next IDLE cycle, provided the requester holds it.
- Non-mul `alu_op` values with sel 00 are ignored: no state change, stall 0.
- A mul_req and rd_req in the same IDLE cycle: the read returns the old HI/LO and the mul starts.
- Reset (synchronous, any state, including mid-RUN):
  - State goes to IDLE.
  - hi, lo, acc, mcand, mplier and cnt all go to 0.
  - busy = done = stall = 0 from the cycle after rst is sampled.
  - An aborted multiply never asserts done and never writes HI/LO.

## Timing

- Reset values: busy 0, done 0, stall 0, hi 0, lo 0, rd_data 0 (sel 00).
- Cycle numbering:
  - Accept happens in IDLE cycle T (mul_req sampled at the end of T).
  - RUN occupies cycles T+1 .. T+WIDTH, with busy = 1.
  - DONE is cycle T+WIDTH+1: done = 1 and hi/lo are valid.
  - IDLE resumes at T+WIDTH+2.
- Latency from accept to done is WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back issue interval is WIDTH+2 cycles.
- busy, done and hi/lo are registered or decoded from state only.
- stall and rd_data are combinational from inputs and registers. The controller must sample them in the same cycle.

## Test plan

- Reset: hold rst for 2 cycles mid-random traffic. Required response: hi=0, lo=0, busy=0, done=0, stall=0, and rd_data=0 for sel 01 and for sel 10.
- Basic multiply: mul with a=7, b=6, accepted at T. Required response: busy=1 over T+1..T+32; done=1 only at T+33 with hi=0, lo=42; then sel=10 gives rd_data=42.
- Full width: a=b=0xFFFFFFFF. Required response: hi=0xFFFFFFFE, lo=0x00000001. Also check a=0x80000000, b=2, which requires hi=1, lo=0.
- Hazards:
  - sel=01 during RUN: stall=1, and rd_data shows the old hi.
  - A second mul during RUN: stall=1 and no restart. If held, it is accepted at the first IDLE cycle and its done arrives WIDTH+1 cycles later.
- Abort: rst at the 10th RUN cycle. Required response: IDLE next cycle, hi=lo=0, and no done pulse in the following 40 cycles.
- Non-mul ops: op_valid with alu_op=3'b010 and sel=00. Required response: busy stays 0, stall=0, hi/lo unchanged.
- Same-cycle read and mul in IDLE: mul with sel=10 in the same IDLE cycle. Required response: rd_data returns the old lo and the multiply starts.
